// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel programmable clock-enable generator.
// Each channel produces a one-cycle tick per divided period and a registered
// square wave, all in the `clock` domain. Divisor updates are staged in a
// shadow register and take effect only at a period boundary or sync_restart.
// Optional feature macro: CLKDIV_DUTY_EN adds the wr_high port and a
// programmable per-channel high threshold for wave_out.
module clock_divider_multi #(
    parameter int NUM_CH      = 4,
    parameter int WIDTH       = 16,
    parameter int CH_W        = 2,
    parameter int DEFAULT_DIV = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [WIDTH-1:0]  wr_div,
`ifdef CLKDIV_DUTY_EN
    input  logic [WIDTH-1:0]  wr_high,
`endif
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic              sync_restart,
    output logic [NUM_CH-1:0] tick_out,
    output logic [NUM_CH-1:0] wave_out,
    output logic [NUM_CH-1:0] pending
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
`ifdef CLKDIV_DUTY_EN
    localparam logic [WIDTH-1:0] RST_THR = WIDTH'(DEFAULT_DIV / 2);
`endif

    logic [WIDTH-1:0]  r_cnt     [NUM_CH];
    logic [WIDTH-1:0]  r_div_act [NUM_CH];
    logic [WIDTH-1:0]  r_div_sh  [NUM_CH];
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_tick;
    logic [NUM_CH-1:0] r_wave;

    logic [WIDTH-1:0]  w_d       [NUM_CH];
    logic [NUM_CH-1:0] w_wr_hit;
    logic [NUM_CH-1:0] w_bound;

    logic [WIDTH-1:0]  w_cnt_nx  [NUM_CH];
    logic [WIDTH-1:0]  w_act_nx  [NUM_CH];
    logic [WIDTH-1:0]  w_sh_nx   [NUM_CH];
    logic [NUM_CH-1:0] w_pend_nx;
    logic [NUM_CH-1:0] w_tick_nx;
    logic [NUM_CH-1:0] w_wave_nx;

`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0]  r_thr_act [NUM_CH];
    logic [WIDTH-1:0]  r_thr_sh  [NUM_CH];
    logic [WIDTH-1:0]  w_thr_act_nx [NUM_CH];
    logic [WIDTH-1:0]  w_thr_sh_nx  [NUM_CH];
`endif

    // Effective divisor, write decode and period-boundary detect per channel
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_d[i]      = (r_div_act[i] == '0) ? WIDTH'(1) : r_div_act[i];
            w_wr_hit[i] = wr_en && (32'(wr_ch) == i);
            w_bound[i]  = sync_restart || (ch_enable[i] && (r_cnt[i] == w_d[i] - WIDTH'(1)));
        end
    end

    // Next-state for counters, divisor staging, tick and wave
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cnt_nx[i]  = r_cnt[i];
            w_act_nx[i]  = r_div_act[i];
            w_sh_nx[i]   = r_div_sh[i];
            w_pend_nx[i] = r_pend[i];
            w_tick_nx[i] = 1'b0;
            w_wave_nx[i] = r_wave[i];
`ifdef CLKDIV_DUTY_EN
            w_thr_act_nx[i] = r_thr_act[i];
            w_thr_sh_nx[i]  = r_thr_sh[i];
`endif
            if (sync_restart) begin
                w_cnt_nx[i] = '0;
            end else if (ch_enable[i]) begin
                if (w_bound[i]) begin
                    w_cnt_nx[i]  = '0;
                    w_tick_nx[i] = 1'b1;
                end else begin
                    w_cnt_nx[i] = r_cnt[i] + WIDTH'(1);
                end
            end
            // Transfer uses the shadow value from before this cycle's write,
            // so a write landing on a boundary waits for the next one.
            if (w_bound[i] && r_pend[i]) begin
                w_act_nx[i]  = r_div_sh[i];
                w_pend_nx[i] = 1'b0;
`ifdef CLKDIV_DUTY_EN
                w_thr_act_nx[i] = r_thr_sh[i];
`endif
            end
            if (w_wr_hit[i]) begin
                w_sh_nx[i]   = wr_div;
                w_pend_nx[i] = 1'b1;
`ifdef CLKDIV_DUTY_EN
                w_thr_sh_nx[i] = wr_high;
`endif
            end
            if (sync_restart || ch_enable[i]) begin
`ifdef CLKDIV_DUTY_EN
                w_wave_nx[i] = (w_cnt_nx[i] >= w_thr_act_nx[i]);
`else
                // max(div,1)>>1 equals div>>1 for every div, so no clamp needed
                w_wave_nx[i] = (w_cnt_nx[i] >= (w_act_nx[i] >> 1));
`endif
            end
        end
    end

    // Channel state registers with asynchronous active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_cnt[i]     <= '0;
                r_div_act[i] <= RST_DIV;
                r_div_sh[i]  <= RST_DIV;
`ifdef CLKDIV_DUTY_EN
                r_thr_act[i] <= RST_THR;
                r_thr_sh[i]  <= RST_THR;
`endif
            end
            r_pend <= '0;
            r_tick <= '0;
            r_wave <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_cnt[i]     <= w_cnt_nx[i];
                r_div_act[i] <= w_act_nx[i];
                r_div_sh[i]  <= w_sh_nx[i];
`ifdef CLKDIV_DUTY_EN
                r_thr_act[i] <= w_thr_act_nx[i];
                r_thr_sh[i]  <= w_thr_sh_nx[i];
`endif
            end
            r_pend <= w_pend_nx;
            r_tick <= w_tick_nx;
            r_wave <= w_wave_nx;
        end
    end

    assign tick_out = r_tick;
    assign wave_out = r_wave;
    assign pending  = r_pend;

endmodule

// File: tb/tb_clock_divider_multi.sv
// Scoreboard bench for clock_divider_multi: a behavioural model predicts the
// outputs of every cycle when stimulus is applied; the prediction is queued
// and compared after the clock edge. Directed checks cover tick timing.
module tb_clock_divider_multi;

    localparam int NUM_CH      = 4;
    localparam int WIDTH       = 16;
    localparam int CH_W        = 3;
    localparam int DEFAULT_DIV = 2;

    logic              clock = 1'b0;
    logic              resetn;
    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic [WIDTH-1:0]  wr_div;
`ifdef CLKDIV_DUTY_EN
    logic [WIDTH-1:0]  wr_high;
`endif
    logic [NUM_CH-1:0] ch_enable;
    logic              sync_restart;
    logic [NUM_CH-1:0] tick_out;
    logic [NUM_CH-1:0] wave_out;
    logic [NUM_CH-1:0] pending;

    always #5 clock = ~clock;

    clock_divider_multi #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .CH_W        (CH_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_div       (wr_div),
`ifdef CLKDIV_DUTY_EN
        .wr_high      (wr_high),
`endif
        .ch_enable    (ch_enable),
        .sync_restart (sync_restart),
        .tick_out     (tick_out),
        .wave_out     (wave_out),
        .pending      (pending)
    );

    int total = 0;
    int bad   = 0;
    logic [3*NUM_CH-1:0] exp_q[$];

    int m_cnt [NUM_CH];
    int m_act [NUM_CH];
    int m_sh  [NUM_CH];
    bit m_pend[NUM_CH];
    bit m_tick[NUM_CH];
    bit m_wave[NUM_CH];
`ifdef CLKDIV_DUTY_EN
    int m_thr_act[NUM_CH];
    int m_thr_sh [NUM_CH];
`endif
    int ft[NUM_CH];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_cnt[c] = 0; m_act[c] = DEFAULT_DIV; m_sh[c] = DEFAULT_DIV;
            m_pend[c] = 1'b0; m_tick[c] = 1'b0; m_wave[c] = 1'b0;
`ifdef CLKDIV_DUTY_EN
            m_thr_act[c] = DEFAULT_DIV / 2; m_thr_sh[c] = DEFAULT_DIV / 2;
`endif
        end
    endfunction

    function automatic void model_step();
        for (int c = 0; c < NUM_CH; c++) begin
            int  d;
            int  dn;
            bit  bnd;
            d   = (m_act[c] == 0) ? 1 : m_act[c];
            bnd = 1'b0;
            m_tick[c] = 1'b0;
            if (sync_restart) begin
                m_cnt[c] = 0;
                bnd = 1'b1;
            end else if (ch_enable[c]) begin
                if (m_cnt[c] == d - 1) begin
                    m_cnt[c] = 0; m_tick[c] = 1'b1; bnd = 1'b1;
                end else begin
                    m_cnt[c] = m_cnt[c] + 1;
                end
            end
            if (bnd && m_pend[c]) begin
                m_act[c] = m_sh[c]; m_pend[c] = 1'b0;
`ifdef CLKDIV_DUTY_EN
                m_thr_act[c] = m_thr_sh[c];
`endif
            end
            if (wr_en && (int'(wr_ch) == c)) begin
                m_sh[c] = int'(wr_div); m_pend[c] = 1'b1;
`ifdef CLKDIV_DUTY_EN
                m_thr_sh[c] = int'(wr_high);
`endif
            end
            if (sync_restart || ch_enable[c]) begin
                dn = (m_act[c] == 0) ? 1 : m_act[c];
`ifdef CLKDIV_DUTY_EN
                m_wave[c] = (m_cnt[c] >= m_thr_act[c]);
`else
                m_wave[c] = (m_cnt[c] >= dn / 2);
`endif
            end
        end
    endfunction

    function automatic logic [3*NUM_CH-1:0] model_out();
        logic [NUM_CH-1:0] p, w, t;
        for (int c = 0; c < NUM_CH; c++) begin
            p[c] = m_pend[c]; w[c] = m_wave[c]; t[c] = m_tick[c];
        end
        return {p, w, t};
    endfunction

    // One clock: predict, queue, clock, compare against the queued prediction
    task automatic step();
        logic [3*NUM_CH-1:0] e;
        model_step();
        exp_q.push_back(model_out());
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_eq("cycle", 32'({pending, wave_out, tick_out}), 32'(e));
    endtask

    // Run n cycles, recording the cycle index of each channel's first tick
    task automatic run_first(input int n);
        for (int c = 0; c < NUM_CH; c++) ft[c] = 0;
        for (int k = 1; k <= n; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++)
                if (ft[c] == 0 && tick_out[c]) ft[c] = k;
        end
    endtask

    task automatic wr(input int ch, input int div, input int high);
        wr_en  = 1'b1;
        wr_ch  = CH_W'(ch);
        wr_div = WIDTH'(div);
`ifdef CLKDIV_DUTY_EN
        wr_high = WIDTH'(high);
`else
        if (high != 0) $display("note: wr_high ignored in this build");
`endif
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_div = '0;
`ifdef CLKDIV_DUTY_EN
        wr_high = '0;
`endif
        ch_enable = '0; sync_restart = 1'b0;
        model_reset();
        #12;
        check_eq("rst_out", 32'({pending, wave_out, tick_out}), 32'h0);
        @(posedge clock); #1;
        resetn = 1'b1;

        // Default divide-by-2 on channel 0 only
        ch_enable = 4'b0001;
        run_first(4);
        check_eq("ch0_first_tick", ft[0], 2);
        check_eq("ch1_idle_tick", ft[1], 0);

        // Channel 1 divisor change to 5 staged at a boundary
        ch_enable = 4'b0011;
        step();
        wr(1, 5, 0);
        check_eq("ch1_pend_set", 32'(pending[1]), 1);
        run_first(2);
        check_eq("ch1_old_period", ft[1], 2);
        check_eq("ch1_pend_clr", 32'(pending[1]), 0);
        run_first(5);
        check_eq("ch1_new_period", ft[1], 5);

        // Divisors 0 and 1 both mean divide-by-1; out-of-range channel ignored
        ch_enable = 4'b0111;
        wr(2, 0, 0);
        wr(2, 1, 0);
        run_first(4);
        run_first(3);
        check_eq("ch2_div1_tick", ft[2], 1);
        check_eq("ch2_div1_wave", 32'(wave_out[2]), 1);
        wr(7, 9, 0);
        check_eq("bad_ch_pend", 32'(pending), 0);
        run_first(12);

        // Enable freeze mid-period on channel 0 at D=6
        wr(0, 6, 3);
        run_first(3);
        check_eq("ch0_d6_applied", 32'(pending[0]), 0);
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        run_first(3);
        ch_enable = 4'b0110;
        run_first(10);
        check_eq("ch0_frozen_tick", ft[0], 0);
        check_eq("ch0_frozen_wave", 32'(wave_out[0]), 1);
        ch_enable = 4'b0111;
        run_first(4);
        check_eq("ch0_resume_tick", ft[0], 3);

        // sync_restart realigns phases and applies a pending divisor at once
        wr(0, 3, 1);
        wr(1, 4, 2);
        run_first(8);
        check_eq("pre_sync_pend", 32'(pending), 0);
        ch_enable = 4'b0111;
        wr(3, 7, 3);
        check_eq("ch3_pend_set", 32'(pending[3]), 1);
        ch_enable = 4'b1111;
        sync_restart = 1'b1;
        step();
        sync_restart = 1'b0;
        check_eq("sync_pend_clr", 32'(pending), 0);
        run_first(8);
        check_eq("sync_ch0", ft[0], 3);
        check_eq("sync_ch1", ft[1], 4);
        check_eq("sync_ch2", ft[2], 1);
        check_eq("sync_ch3", ft[3], 7);

        // Asynchronous reset between clock edges
        run_first(2);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_out", 32'({pending, wave_out, tick_out}), 32'h0);
        model_reset();
        #3;
        resetn = 1'b1;
        run_first(5);
        check_eq("rst_div_ch0", ft[0], 2);
        check_eq("rst_div_ch3", ft[3], 2);

`ifdef CLKDIV_DUTY_EN
        begin
            int hi;
            wr(0, 8, 6);
            run_first(10);
            hi = 0;
            for (int k = 0; k < 8; k++) begin
                step();
                hi += int'(wave_out[0]);
            end
            check_eq("duty_high_cycles", hi, 2);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
